// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared types and helpers for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One registered read port with zero / bypass / hold selection.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic              i_idle,
  input  logic              i_wr_eff,
  input  logic [ADDR_W-1:0] i_rw,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_arr_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;

  always_comb begin
    w_data_nxt = r_data;
    if (i_re) begin
      if (!i_idle)
        w_data_nxt = '0;
      else if ((ZERO_REG != 0) && (i_ra == '0))
        w_data_nxt = '0;
      else if ((BYPASS != 0) && i_wr_eff && (i_rw == i_ra))
        w_data_nxt = i_wdata;
      else
        w_data_nxt = i_arr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn)
      r_data <= '0;
    else
      r_data <= w_data_nxt;
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Flip-flop register file, N_RD read ports, one write port,
//               write-first bypass and a sequenced bulk-clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_arstn,
  input  logic [N_RD*ADDR_W-1:0]   i_RA,
  input  logic [N_RD-1:0]          i_RE,
  output logic [N_RD*DATA_W-1:0]   o_BUS,
  input  logic                     i_WE,
  input  logic [ADDR_W-1:0]        i_RW,
  input  logic [DATA_W-1:0]        i_BUS_W,
  input  logic                     i_CLR,
  output logic                     o_BUSY
);

  localparam int c_depth = depth_of(ADDR_W);
  localparam int c_cnt_w = clog2(c_depth);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_depth - 1);

  logic [DATA_W-1:0]  r_mem [c_depth];
  rf_state_t          r_state;
  rf_state_t          w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_idle;
  logic               w_clr_en;
  logic               w_wr_eff;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_CLR) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == c_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Writes to r0 are squashed here so the bypass path never forwards them.
  always_comb begin
    w_idle   = (r_state == ST_IDLE);
    w_clr_en = (r_state == ST_CLEAR);
    o_BUSY   = w_clr_en;
    w_wr_eff = i_WE && w_idle && !((ZERO_REG != 0) && (i_RW == '0));
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      for (int i = 0; i < c_depth; i++)
        r_mem[i] <= '0;
    end else if (w_clr_en) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_eff) begin
      r_mem[i_RW] <= i_BUS_W;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd_port
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_arr_rd;

    assign w_ra     = i_RA[k*ADDR_W +: ADDR_W];
    assign w_arr_rd = r_mem[w_ra];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .i_clk      (i_clk),
      .i_arstn    (i_arstn),
      .i_re       (i_RE[k]),
      .i_ra       (w_ra),
      .i_idle     (w_idle),
      .i_wr_eff   (w_wr_eff),
      .i_rw       (i_RW),
      .i_wdata    (i_BUS_W),
      .i_arr_data (w_arr_rd),
      .o_data     (o_BUS[k*DATA_W +: DATA_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Directed and randomized bench for register_file_mp with a
//               behavioural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int N_RD     = 2;
  localparam int ZERO_REG = 1;
  localparam int BYPASS   = 1;
  localparam int DEPTH    = 32;

  logic                   clk;
  logic                   arstn;
  logic [N_RD*ADDR_W-1:0] ra;
  logic [N_RD-1:0]        re;
  logic [N_RD*DATA_W-1:0] bus;
  logic                   we;
  logic [ADDR_W-1:0]      rw;
  logic [DATA_W-1:0]      wdata;
  logic                   clr;
  logic                   busy;

  int n_total;
  int n_bad;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_bus [N_RD];
  int                m_clr_left;

  register_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_dut (
    .i_clk   (clk),
    .i_arstn (arstn),
    .i_RA    (ra),
    .i_RE    (re),
    .o_BUS   (bus),
    .i_WE    (we),
    .i_RW    (rw),
    .i_BUS_W (wdata),
    .i_CLR   (clr),
    .o_BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < N_RD; k++) m_bus[k] = '0;
    m_clr_left = 0;
  endtask

  // One clock edge of the register file, described by its visible rules.
  task automatic model_step();
    bit                idle;
    bit                wr_eff;
    logic [ADDR_W-1:0] a;
    idle   = (m_clr_left == 0);
    wr_eff = idle && we && !(ZERO_REG != 0 && rw == 0);
    for (int k = 0; k < N_RD; k++) begin
      a = ra[k*ADDR_W +: ADDR_W];
      if (re[k]) begin
        if (!idle)                               m_bus[k] = '0;
        else if (ZERO_REG != 0 && a == 0)        m_bus[k] = '0;
        else if (BYPASS != 0 && wr_eff && rw == a) m_bus[k] = wdata;
        else                                     m_bus[k] = m_mem[a];
      end
    end
    if (wr_eff) m_mem[rw] = wdata;
    if (!idle) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else if (clr) begin
      m_clr_left = DEPTH;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N_RD; k++)
      check($sformatf("bus%0d", k), 64'(bus[k*DATA_W +: DATA_W]), 64'(m_bus[k]));
    check("busy", 64'(busy), 64'(m_clr_left != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] r, input logic c);
    we = w; rw = wa; wdata = wd; ra = {a1, a0}; re = r; clr = c;
  endtask

  // Called just after a rising edge: asserts reset mid-cycle, then releases.
  task automatic do_reset();
    #2;
    arstn = 1'b0;
    #1;
    model_reset();
    check("rst_bus", 64'(bus), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #2;
    arstn = 1'b1;
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
    if (busy) check({tag, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(0, 0, 0, 5'(i), 5'(i + 1), 2'b11, 0);
      tick();
      check(tag, 64'(bus), 64'd0);
    end
  endtask

  initial begin
    int n;
    n_total = 0;
    n_bad   = 0;
    arstn   = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 0);
    model_reset();
    #7;
    check("por_bus", 64'(bus), 64'd0);
    check("por_busy", 64'(busy), 64'd0);
    arstn = 1'b1;

    drive(0, 0, 0, 5, 5, 2'b11, 0);
    tick();
    check("r5_zero", 64'(bus), 64'd0);

    // write then read back
    drive(1, 7, 32'hDEADBEEF, 0, 0, 2'b00, 0);
    tick();
    drive(0, 0, 0, 7, 0, 2'b01, 0);
    tick();
    check("wr_rd_r7", 64'(bus[31:0]), 64'hDEADBEEF);

    // bypass on same address
    drive(1, 3, 32'h11, 0, 0, 2'b00, 0);
    tick();
    drive(1, 3, 32'h22, 0, 3, 2'b10, 0);
    tick();
    check("bypass_r3", 64'(bus[63:32]), 64'h22);
    drive(1, 0, 32'hFFFF, 0, 0, 2'b11, 0);
    tick();
    check("zero_bypass", 64'(bus), 64'd0);
    drive(0, 0, 0, 0, 3, 2'b11, 0);
    tick();
    check("zero_read", 64'(bus[31:0]), 64'd0);

    // port 1 holds r7 while its address wanders
    drive(0, 0, 0, 0, 7, 2'b10, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, (i == 1) ? 5'd7 : 5'd3, 5'(i + 10), 2'b01, 0);
      tick();
      check("hold_p1", 64'(bus[63:32]), 64'hDEADBEEF);
    end
    check("track_p0", 64'(bus[31:0]), 64'h22);

    // fill with index, then clear
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(i), 32'(i), 0, 0, 2'b00, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 1);
    tick();
    clr = 0;
    n = 0;
    while (busy && n < 100) begin
      we = (n == 4); rw = 9; wdata = 32'h99;
      tick();
      n++;
    end
    we = 0;
    check("busy_len", 64'(n), 64'd32);
    check_all_zero("after_clr");

    // level clear re-arms after one idle cycle
    drive(0, 0, 0, 0, 0, 2'b00, 1);
    tick();
    wait_idle("clr_lvl", n);
    check("busy_len_lvl", 64'(n), 64'd32);
    tick();
    check("rearm", 64'(busy), 64'd1);
    clr = 0;
    wait_idle("clr_lvl2", n);

    // reset while the clear engine is at entry 10
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(i), 32'h100 + 32'(i), 0, 0, 2'b00, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 1);
    tick();
    clr = 0;
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    check_all_zero("after_rst");
    drive(1, 12, 32'hA5A5_5A5A, 0, 0, 2'b00, 0);
    tick();
    drive(0, 0, 0, 0, 12, 2'b10, 0);
    tick();
    check("post_rst_wr", 64'(bus[63:32]), 64'hA5A55A5A);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      we    = $urandom_range(0, 1) == 1;
      rw    = 5'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      ra    = 10'($urandom);
      re    = 2'($urandom);
      clr   = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 7) == 0) ra[9:5] = rw;
      tick();
    end
    clr = 0;
    wait_idle("rand_end", n);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
